// File: rtl/aes128_enc_seq.sv
// rtl/aes128_enc_seq.sv - AES-128 block encryption sequencer driving an external aes64 core
module aes128_enc_seq (
    input  logic         g_clk,
    input  logic         g_resetn,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [127:0] req_key,
    input  logic [127:0] req_pt,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [127:0] rsp_ct,
    output logic         core_valid,
    output logic         core_mix,
    output logic         core_op_enc,
    output logic         core_op_dec,
    output logic         core_op_imix,
    output logic         core_op_ks1,
    output logic         core_op_ks2,
    output logic [63:0]  core_rs1,
    output logic [63:0]  core_rs2,
    input  logic [63:0]  core_rd,
    input  logic         core_ready
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        KS1  = 3'd1,
        KS2L = 3'd2,
        KS2H = 3'd3,
        ENCL = 3'd4,
        ENCH = 3'd5,
        DONE = 3'd6
    } state_t;

    state_t        state_q, state_d;
    logic [127:0]  s_q, s_d;      // cipher state after the latest AddRoundKey
    logic [127:0]  rk_q, rk_d;    // current round key
    logic [63:0]   t_q, t_d;      // holds KS1 word or low half of the round output
    logic [3:0]    rnd_q, rnd_d;  // round number 1..10
    logic          core_done;
    logic          last_round;

    // Operand and op outputs come straight from registered state, so they
    // cannot move while a core transaction is stalled.
    assign core_valid   = (state_q == KS1) || (state_q == KS2L) || (state_q == KS2H) ||
                          (state_q == ENCL) || (state_q == ENCH);
    assign core_done    = core_valid && core_ready;
    assign last_round   = (rnd_q == 4'd10);
    assign core_op_dec  = 1'b0;
    assign core_op_imix = 1'b0;
    assign req_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == DONE);
    assign rsp_ct       = rsp_valid ? s_q : 128'd0;

    // State and datapath registers
    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state_q <= IDLE;
            s_q     <= '0;
            rk_q    <= '0;
            t_q     <= '0;
            rnd_q   <= '0;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            rk_q    <= rk_d;
            t_q     <= t_d;
            rnd_q   <= rnd_d;
        end
    end

    // Next-state, datapath updates and core request decode
    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        rk_d        = rk_q;
        t_d         = t_q;
        rnd_d       = rnd_q;
        core_mix    = 1'b0;
        core_op_enc = 1'b0;
        core_op_ks1 = 1'b0;
        core_op_ks2 = 1'b0;
        core_rs1    = 64'd0;
        core_rs2    = 64'd0;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    s_d     = req_pt ^ req_key;
                    rk_d    = req_key;
                    rnd_d   = 4'd1;
                    state_d = KS1;
                end
            end
            KS1: begin
                core_op_ks1 = 1'b1;
                core_rs1    = rk_q[127:64];
                core_rs2    = {60'd0, rnd_q - 4'd1};
                if (core_done) begin
                    t_d     = core_rd;
                    state_d = KS2L;
                end
            end
            KS2L: begin
                core_op_ks2 = 1'b1;
                core_rs1    = t_q;
                core_rs2    = rk_q[63:0];
                if (core_done) begin
                    rk_d[63:0] = core_rd;
                    state_d    = KS2H;
                end
            end
            KS2H: begin
                // rk_q[63:0] already holds the new low half from KS2L
                core_op_ks2 = 1'b1;
                core_rs1    = rk_q[63:0];
                core_rs2    = rk_q[127:64];
                if (core_done) begin
                    rk_d[127:64] = core_rd;
                    state_d      = ENCL;
                end
            end
            ENCL: begin
                core_op_enc = 1'b1;
                core_mix    = !last_round;
                core_rs1    = s_q[63:0];
                core_rs2    = s_q[127:64];
                if (core_done) begin
                    t_d     = core_rd;
                    state_d = ENCH;
                end
            end
            ENCH: begin
                // Swapped operands make the core produce the high half
                core_op_enc = 1'b1;
                core_mix    = !last_round;
                core_rs1    = s_q[127:64];
                core_rs2    = s_q[63:0];
                if (core_done) begin
                    s_d = {core_rd, t_q} ^ rk_q;
                    if (last_round) begin
                        state_d = DONE;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = KS1;
                    end
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_aes128_enc_seq.sv
// tb/tb_aes128_enc_seq.sv - scoreboard bench for aes128_enc_seq with a behavioural aes64 core
module tb_aes128_enc_seq;

    logic         g_clk      = 1'b0;
    logic         g_resetn   = 1'b0;
    logic         req_valid  = 1'b0;
    logic         req_ready;
    logic [127:0] req_key    = '0;
    logic [127:0] req_pt     = '0;
    logic         rsp_valid;
    logic         rsp_ready  = 1'b1;
    logic [127:0] rsp_ct;
    logic         core_valid;
    logic         core_mix;
    logic         core_op_enc;
    logic         core_op_dec;
    logic         core_op_imix;
    logic         core_op_ks1;
    logic         core_op_ks2;
    logic [63:0]  core_rs1;
    logic [63:0]  core_rs2;
    logic [63:0]  core_rd    = '0;
    logic         core_ready = 1'b0;

    aes128_enc_seq dut (
        .g_clk        (g_clk),
        .g_resetn     (g_resetn),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_key      (req_key),
        .req_pt       (req_pt),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_ct       (rsp_ct),
        .core_valid   (core_valid),
        .core_mix     (core_mix),
        .core_op_enc  (core_op_enc),
        .core_op_dec  (core_op_dec),
        .core_op_imix (core_op_imix),
        .core_op_ks1  (core_op_ks1),
        .core_op_ks2  (core_op_ks2),
        .core_rs1     (core_rs1),
        .core_rs2     (core_rs2),
        .core_rd      (core_rd),
        .core_ready   (core_ready)
    );

    always #5 g_clk = ~g_clk;

    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] CT_Z   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    int           checks   = 0;
    int           failures = 0;
    logic [127:0] exp_q[$];
    logic [7:0]   sbox_t[256];

    bit           mon_en      = 1'b0;
    bit           stall_mode  = 1'b0;
    bit           b2b_check   = 1'b0;
    int           hold_at_txn = -1;
    int           neg_cnt     = 0;
    int           txn_cnt     = 0;
    int           stall_cnt   = 0;
    int           acc_neg     = 0;
    int           rsp_neg     = -100;
    int           k_idx;
    int           r_idx;
    bit           in_block      = 1'b0;
    bit           prev_stall    = 1'b0;
    bit           prev_rsp_hold = 1'b0;
    logic [127:0] prev_ct       = '0;
    logic [134:0] prev_bus      = '0;
    logic [134:0] core_bus;

    assign core_bus = {core_valid, core_mix, core_op_enc, core_op_dec, core_op_imix,
                       core_op_ks1, core_op_ks2, core_rs1, core_rs2};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // FIPS text lists byte 0 first; the ports carry byte 0 in bits [7:0]
    function automatic logic [127:0] fips(input logic [127:0] x);
        logic [127:0] y;
        for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
        return y;
    endfunction

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] a);
        logic [7:0] v;
        v = 8'h01;
        for (int k = 0; k < 254; k++) v = gmul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] n);
        case (n)
            4'd0: return 8'h01;
            4'd1: return 8'h02;
            4'd2: return 8'h04;
            4'd3: return 8'h08;
            4'd4: return 8'h10;
            4'd5: return 8'h20;
            4'd6: return 8'h40;
            4'd7: return 8'h80;
            4'd8: return 8'h1b;
            4'd9: return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Behavioural aes64 core: ks1 / ks2 / enc(+mix) on the 64-bit operands
    function automatic logic [63:0] core_model(input logic ks1, input logic ks2, input logic mix,
                                               input logic [63:0] rs1, input logic [63:0] rs2);
        logic [31:0]  w;
        logic [127:0] st;
        logic [63:0]  o;
        logic [7:0]   a0, a1, a2, a3;
        if (ks1) begin
            w = rs1[63:32];
            if (rs2[3:0] != 4'd10) w = {w[7:0], w[31:8]};
            w = {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
            w[7:0] = w[7:0] ^ rcon(rs2[3:0]);
            return {w, w};
        end
        if (ks2) begin
            w = rs1[63:32] ^ rs2[31:0];
            return {w ^ rs2[63:32], w};
        end
        st = {rs2, rs1};
        for (int c = 0; c < 2; c++)
            for (int r = 0; r < 4; r++)
                o[8*(4*c+r) +: 8] = sbox_t[st[8*(4*((c+r)%4)+r) +: 8]];
        if (mix) begin
            for (int c = 0; c < 2; c++) begin
                a0 = o[32*c +: 8];
                a1 = o[32*c+8 +: 8];
                a2 = o[32*c+16 +: 8];
                a3 = o[32*c+24 +: 8];
                o[32*c +: 32] = {xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3),
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3};
            end
        end
        return o;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) sbox_t[i] = sbox_calc(8'(i));
    end

    // Core responder, protocol monitor and response scoreboard
    always @(negedge g_clk) begin
        neg_cnt++;
        if (in_block && hold_at_txn == txn_cnt) core_ready = 1'b0;
        else if (stall_mode) core_ready = ($urandom_range(0, 2) != 0);
        else core_ready = 1'b1;
        if (core_valid && core_ready)
            core_rd = core_model(core_op_ks1, core_op_ks2, core_mix, core_rs1, core_rs2);
        else
            core_rd = {$urandom, $urandom};

        if (mon_en) begin
            if (core_valid) begin
                chki("core_onehot", $countones({core_op_enc, core_op_dec, core_op_imix,
                                                core_op_ks1, core_op_ks2}), 1);
                chki("core_dec_imix", 32'({core_op_dec, core_op_imix}), 0);
            end else begin
                chki("core_idle_zero", 32'(|core_bus), 0);
            end
            if (prev_stall) begin
                chk("core_stall_rs", {core_rs1, core_rs2}, prev_bus[127:0]);
                chki("core_stall_ctl", 32'(core_bus[134:128]), 32'(prev_bus[134:128]));
            end
            if (prev_rsp_hold && rsp_valid) chk("rsp_ct_hold", rsp_ct, prev_ct);
            if (rsp_valid) chki("req_ready_in_done", 32'(req_ready), 0);

            if (in_block && core_valid && core_ready && g_resetn) begin
                k_idx = txn_cnt % 5;
                r_idx = txn_cnt / 5;
                chki("txn_op", 32'({core_op_ks1, core_op_ks2, core_op_enc}),
                     (k_idx == 0) ? 4 : ((k_idx < 3) ? 2 : 1));
                if (k_idx == 0) chki("ks1_rnum", 32'(core_rs2[3:0]), r_idx);
                if (k_idx >= 3) chki("enc_mix", 32'(core_mix), 32'(r_idx != 9));
                txn_cnt++;
            end
            if (in_block && core_valid && !core_ready && g_resetn) stall_cnt++;

            if (in_block && rsp_valid) begin
                chki("latency", neg_cnt - acc_neg - 1, 50 + stall_cnt);
                chki("txn_total", txn_cnt, 50);
                in_block = 1'b0;
            end

            if (rsp_valid && rsp_ready && g_resetn) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got ct %h expected no response", rsp_ct);
                end else begin
                    chk("rsp_ct", rsp_ct, exp_q.pop_front());
                end
                rsp_neg = neg_cnt;
            end

            if (req_valid && req_ready && g_resetn) begin
                if (b2b_check) begin
                    chki("b2b_gap", neg_cnt - rsp_neg, 1);
                    b2b_check = 1'b0;
                end
                in_block  = 1'b1;
                txn_cnt   = 0;
                stall_cnt = 0;
                acc_neg   = neg_cnt;
            end

            if (!g_resetn) begin
                in_block = 1'b0;
                txn_cnt  = 0;
            end
        end

        prev_stall    = core_valid && !core_ready && g_resetn;
        prev_bus      = core_bus;
        prev_rsp_hold = rsp_valid && !rsp_ready && g_resetn;
        prev_ct       = rsp_ct;
    end

    task automatic send(input logic [127:0] key, input logic [127:0] pt,
                        input logic [127:0] ct, input bit push);
        bit acc;
        acc = 1'b0;
        req_key   = fips(key);
        req_pt    = fips(pt);
        req_valid = 1'b1;
        if (push) exp_q.push_back(fips(ct));
        for (int i = 0; i < 3000 && !acc; i++) begin
            @(negedge g_clk);
            acc = req_ready;
            @(posedge g_clk);
            #1;
        end
        chki("send_accept", 32'(acc), 1);
        req_valid = 1'b0;
        req_key   = {$urandom, $urandom, $urandom, $urandom};
        req_pt    = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic wait_quiet();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(posedge g_clk);
            #1;
            ok = (exp_q.size() == 0) && req_ready;
        end
        chki("drain", 32'(ok), 1);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge g_clk);
        #1;
        chki("rst_req_ready", 32'(req_ready), 1);
        chki("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_rsp_ct", rsp_ct, 128'd0);
        chki("rst_core_bus", 32'(|core_bus), 0);
        mon_en   = 1'b1;
        g_resetn = 1'b1;
        @(posedge g_clk);
        #1;

        send(KEY_B, PT_B, CT_B, 1'b1);
        wait_quiet();

        stall_mode = 1'b1;
        send(KEY_C1, PT_C1, CT_C1, 1'b1);
        wait_quiet();
        stall_mode = 1'b0;

        rsp_ready = 1'b0;
        send(KEY_B, PT_B, CT_B, 1'b1);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge g_clk);
            #1;
            seen = rsp_valid;
        end
        chki("done_reached", 32'(seen), 1);
        for (int i = 0; i < 20; i++) begin
            req_valid = ~req_valid;
            req_key   = {$urandom, $urandom, $urandom, $urandom};
            req_pt    = {$urandom, $urandom, $urandom, $urandom};
            @(posedge g_clk);
            #1;
            chk("done_hold_ct", rsp_ct, fips(CT_B));
            chki("done_req_ready", 32'(req_ready), 0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge g_clk);
        #1;
        chki("done_exit_req_ready", 32'(req_ready), 1);
        chki("done_exit_rsp_valid", 32'(rsp_valid), 0);

        hold_at_txn = 23;
        send(KEY_C1, PT_C1, CT_C1, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(posedge g_clk);
            #1;
            seen = (txn_cnt == 23) && core_valid && !core_ready;
        end
        chki("r5_encl_reached", 32'(seen), 1);
        chki("r5_encl_op", 32'({core_op_enc, core_mix}), 3);
        repeat (2) @(posedge g_clk);
        #1;
        g_resetn = 1'b0;
        @(posedge g_clk);
        #1;
        chki("midrst_core_valid", 32'(core_valid), 0);
        chki("midrst_req_ready", 32'(req_ready), 1);
        chki("midrst_rsp_valid", 32'(rsp_valid), 0);
        chk("midrst_rsp_ct", rsp_ct, 128'd0);
        g_resetn    = 1'b1;
        hold_at_txn = -1;
        repeat (3) @(posedge g_clk);
        #1;
        send(KEY_B, PT_B, CT_B, 1'b1);
        wait_quiet();

        send(128'd0, 128'd0, CT_Z, 1'b1);
        b2b_check = 1'b1;
        send(KEY_C1, PT_C1, CT_C1, 1'b1);
        wait_quiet();
        chki("b2b_checked", 32'(b2b_check), 0);

        repeat (5) @(posedge g_clk);
        #1;
        chki("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
